// File: rtl/five_bit_rom_pkg.sv
// Shared widths and types for the five_bit_rom lookup table.
// ADDR_W is derived from DEPTH so the two can never disagree.
package five_bit_rom_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = 5;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/five_bit_rom_table.sv
// Combinational contents of the five_bit_rom: each entry is its address bit-reversed.
// Listed explicitly so the table stays a plain ROM that synthesis can map as it likes.
module five_bit_rom_table
    import five_bit_rom_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        case (addr)
            5'd0:  data = 5'd0;
            5'd1:  data = 5'd16;
            5'd2:  data = 5'd8;
            5'd3:  data = 5'd24;
            5'd4:  data = 5'd4;
            5'd5:  data = 5'd20;
            5'd6:  data = 5'd12;
            5'd7:  data = 5'd28;
            5'd8:  data = 5'd2;
            5'd9:  data = 5'd18;
            5'd10: data = 5'd10;
            5'd11: data = 5'd26;
            5'd12: data = 5'd6;
            5'd13: data = 5'd22;
            5'd14: data = 5'd14;
            5'd15: data = 5'd30;
            5'd16: data = 5'd1;
            5'd17: data = 5'd17;
            5'd18: data = 5'd9;
            5'd19: data = 5'd25;
            5'd20: data = 5'd5;
            5'd21: data = 5'd21;
            5'd22: data = 5'd13;
            5'd23: data = 5'd29;
            5'd24: data = 5'd3;
            5'd25: data = 5'd19;
            5'd26: data = 5'd11;
            5'd27: data = 5'd27;
            5'd28: data = 5'd7;
            5'd29: data = 5'd23;
            5'd30: data = 5'd15;
            5'd31: data = 5'd31;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/five_bit_rom.sv
// Registered bit-reversal ROM: out follows table[in] one clock later.
// Optional ROM_PARITY_EN adds out_parity, the XOR of out, aligned with it.
module five_bit_rom
    import five_bit_rom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] in,
    output logic [DATA_W-1:0] out
`ifdef ROM_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;

    five_bit_rom_table u_table (
        .addr (in),
        .data (rom_data)
    );

    always_comb begin
        out_d = rom_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef ROM_PARITY_EN
    logic parity_d;
    logic parity_q;

    // Computed from the next out value so both flops update on the same edge.
    always_comb begin
        parity_d = ^out_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_five_bit_rom.sv
// Self-checking bench for five_bit_rom against an arithmetic bit-reverse model.
// Define ROM_PARITY_EN for both DUT and bench to exercise out_parity.
module tb_five_bit_rom;

    logic       clk;
    logic       rst;
    logic [4:0] in;
    logic [4:0] out;
`ifdef ROM_PARITY_EN
    logic       out_parity;
`endif

    int vectors;
    int miscompares;

    five_bit_rom dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .out        (out)
`ifdef ROM_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: rebuild the word by shifting address bits out LSB-first.
    function automatic logic [4:0] rev5(input int a);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) begin
            r = r * 2 + ((a >> i) % 2);
        end
        return r[4:0];
    endfunction

    function automatic logic par5(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 5; i++) c += (v >> i) % 2;
        return (c % 2) == 1;
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in  = 5'd0;
        #1;
        vectors++;
        if (out !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_async: out=%0d expected=0", out);
        end
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        vectors++;
        if (out !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_first_edge: out=%0d expected=0", out);
        end
        $display("reset: out=%0d", out);
    endtask

    task automatic test_one_hot();
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            in = 5'(1 << k);
            edge_sample();
            vectors++;
            if (out !== rev5(1 << k)) begin
                miscompares++;
                $display("FAIL one_hot in=%0d: out=%0d expected=%0d", 1 << k, out, rev5(1 << k));
            end
            $display("one_hot: in=%0d out=%0d", 1 << k, out);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            in = 5'(a);
            edge_sample();
            vectors++;
            if (out !== rev5(a)) begin
                miscompares++;
                $display("FAIL sweep in=%0d: out=%0d expected=%0d", a, out, rev5(a));
            end
            $display("sweep: in=%0d out=%0d", a, out);
        end
    endtask

    task automatic test_spot();
        int addrs[4] = '{3, 5, 31, 0};
        int exps[4]  = '{24, 20, 31, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in = 5'(addrs[i]);
            edge_sample();
            vectors++;
            if (out !== 5'(exps[i])) begin
                miscompares++;
                $display("FAIL spot in=%0d: out=%0d expected=%0d", addrs[i], out, exps[i]);
            end
            $display("spot: in=%0d out=%0d", addrs[i], out);
        end
    endtask

    task automatic test_latency_hold();
        @(negedge clk);
        in = 5'd6;
        edge_sample();
        vectors++;
        if (out !== 5'd12) begin
            miscompares++;
            $display("FAIL latency_load6: out=%0d expected=12", out);
        end
        @(negedge clk);
        in = 5'd12;
        #1;
        vectors++;
        if (out !== 5'd12) begin
            miscompares++;
            $display("FAIL latency_between_edges: out=%0d expected=12", out);
        end
        for (int c = 0; c < 10; c++) begin
            edge_sample();
            vectors++;
            if (out !== 5'd6) begin
                miscompares++;
                $display("FAIL hold cycle=%0d: out=%0d expected=6", c, out);
            end
        end
        $display("latency_hold: out=%0d", out);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in = 5'd3;
        edge_sample();
        vectors++;
        if (out !== 5'd24) begin
            miscompares++;
            $display("FAIL reset_mid_pre: out=%0d expected=24", out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (out !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async: out=%0d expected=0", out);
        end
`ifdef ROM_PARITY_EN
        vectors++;
        if (out_parity !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_parity: parity=%0b expected=0", out_parity);
        end
`endif
        #1;
        rst = 1'b0;
        edge_sample();
        vectors++;
        if (out !== 5'd24) begin
            miscompares++;
            $display("FAIL reset_mid_release: out=%0d expected=24", out);
        end
        $display("reset_mid: out=%0d", out);
    endtask

`ifdef ROM_PARITY_EN
    task automatic test_parity();
        int addrs[2] = '{7, 3};
        int outs[2]  = '{28, 24};
        logic pars[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in = 5'(addrs[i]);
            edge_sample();
            vectors++;
            if (out !== 5'(outs[i]) || out_parity !== pars[i]) begin
                miscompares++;
                $display("FAIL parity in=%0d: out=%0d parity=%0b expected out=%0d parity=%0b",
                         addrs[i], out, out_parity, outs[i], pars[i]);
            end
            $display("parity: in=%0d out=%0d parity=%0b", addrs[i], out, out_parity);
        end
    endtask
`endif

    task automatic test_random();
        int   a;
        logic r;
        logic [4:0] exp_out;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a = int'($urandom_range(0, 31));
            r = ($urandom_range(0, 15) == 0);
            in  = 5'(a);
            rst = r;
            edge_sample();
            exp_out = r ? 5'd0 : rev5(a);
            vectors++;
            if (out !== exp_out) begin
                miscompares++;
                $display("FAIL random n=%0d in=%0d rst=%0b: out=%0d expected=%0d", n, a, r, out, exp_out);
            end
`ifdef ROM_PARITY_EN
            vectors++;
            if (out_parity !== (r ? 1'b0 : par5(rev5(a)))) begin
                miscompares++;
                $display("FAIL random_parity n=%0d in=%0d: parity=%0b", n, a, out_parity);
            end
`endif
            $display("random: n=%0d in=%0d rst=%0b out=%0d", n, a, r, out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in          = 5'd0;
        test_reset();
        test_one_hot();
        test_sweep();
        test_spot();
        test_latency_hold();
        test_reset_mid();
`ifdef ROM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/five_bit_rom.md
Name: five_bit_rom

Overview:
- Fixed-content 32-entry by 5-bit lookup ROM with a registered output.
- Maps a 5-bit address to a 5-bit code word: the bit-reversal of the address.
- Used as a small constant translation table in the cruise-control datapath, for example to re-order one-hot selector codes.
- One clock domain; one-cycle read latency.

Parameters:
- none. Widths are fixed constants, defined in the shared package (ADDR_W = 5, DATA_W = 5, DEPTH = 32).

Ports:
- clk  input  1  system clock; rising-edge active
- rst  input  1  reset; asynchronous, active-high
- in  input  5  read address
- out  output  5  registered ROM data for the address sampled on the previous rising edge
- out_parity  output  1  present only with ROM_PARITY_EN; registered XOR of all out bits

Behaviour:
- Interface rule (already decided): one clock, clk; reset is asynchronous and active-high, named rst.
- ROM contents: entry a holds a with its bit order reversed.
  - data[4] = a[0], data[3] = a[1], data[2] = a[2], data[1] = a[3], data[0] = a[4].
  - Examples: 0->0, 1->16, 2->8, 3->24, 4->4, 8->2, 16->1, 31->31.
  - All 32 entries are defined; there are no don't-care or X entries.
- Read path: combinational lookup of in, captured into the out register on every rising clk edge.
  - Latency is exactly one cycle: in is sampled at edge N, and the matching data appears on out after edge N.
  - There is no enable; a read occurs every cycle.
- Holding in constant keeps out constant. No glitches on out between edges, since out is driven directly from a flop.
- Reset:
  - While rst is high, out is 0 (and out_parity is 0), immediately and independent of clk.
  - Reset asserted mid-operation clears out asynchronously.
  - After deassertion, the first rising edge loads table[in].
- Reset wins over a simultaneous clock edge.
- The ROM is read-only. No write port; contents are fixed at synthesis time.
- Out-of-range addresses cannot occur: the full 5-bit space is populated.
- Input X or Z is not legal stimulus. No protection is required.

Optional Feature:
- Macro: ROM_PARITY_EN
- Defined:
  - Adds the out_parity output port.
  - out_parity is registered in the same cycle as out and equals the XOR reduction of the next out value, so it is aligned with out.
  - Reset value is 0.
- Not defined: the out_parity port and its logic are absent, and the module has exactly the ports clk, rst, in, out.

Decomposition:
- Shared package five_bit_rom_pkg holds:
  - constants ADDR_W = 5, DATA_W = 5, DEPTH = 32;
  - a typedef for the 5-bit address;
  - a typedef for the 5-bit data word.
- One natural sub-module: five_bit_rom_table.
  - Purely combinational, 5-bit address in, 5-bit data out.
  - Implemented as an explicit 32-case table.
  - The top level instantiates it and adds the output register(s) and reset.

Test Plan:
- Reset: assert rst with in = 0 and no clock edges -> out = 0 immediately. Deassert and clock once -> out = 0.
- One-hot walk: in = 16, 8, 4, 2, 1, each held one cycle -> out = 1, 2, 4, 8, 16 respectively, each one cycle after the input is applied.
- Full sweep: in = 0..31, one per cycle -> out equals bit-reverse(in) one cycle later. Spot checks: 3->24, 5->20, 31->31, 0->0.
- Latency and hold:
  - Change in from 6 to 12 between edges -> out stays 12 (table[6]) until the next edge, then becomes 6 (table[12]).
  - Holding in = 12 for 10 cycles -> out remains 6.
- Reset mid-operation:
  - With out = 24, pulse rst between clock edges -> out goes to 0 without an edge.
  - After release with in = 3, the next edge gives out = 24.
- With ROM_PARITY_EN:
  - in = 7 -> out = 28, out_parity = 1.
  - in = 3 -> out = 24, out_parity = 0.
  - rst -> out_parity = 0.
